// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control sequencer for the MIPS_new datapath: walks fetch/decode/execute/
// memory/writeback states and emits Moore-decoded enables, mux selects and a retire count.
module mips_multicycle_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  output logic [3:0]           count_state,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic                 reg_dst,
  output logic                 alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 mem_we,
  output logic                 mem_to_reg,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXECUTE   = 4'd3;
  localparam logic [3:0] S_WRITEBACK = 4'd4;
  localparam logic [3:0] S_MEMORY    = 4'd5;
  localparam logic [3:0] S_TRAP      = 4'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0]           state_q, state_d;
  logic [5:0]           op_q, op_d;
  logic [5:0]           fn_q, fn_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 legal;
  logic                 retire;
  logic                 alu_phase;

  // Legality is judged on the live IR fields during DECODE, before they are latched
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = (funct == 6'h20) || (funct == 6'h22) ||
                        (funct == 6'h24) || (funct == 6'h25);
      OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE:   state_d = ((op_q == OP_LW) || (op_q == OP_SW)) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    state_d = (op_q == OP_SW) ? (run ? S_FETCH : S_IDLE) : S_WRITEBACK;
      S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:      state_d = run ? S_TRAP : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // An instruction retires as it leaves WRITEBACK, or leaves MEMORY when it is a store
  always_comb begin
    retire = (state_q == S_WRITEBACK) || ((state_q == S_MEMORY) && (op_q == OP_SW));
    cnt_d  = cnt_q + CNT_WIDTH'(retire);
    op_d   = (state_q == S_DECODE) ? opcode : op_q;
    fn_d   = (state_q == S_DECODE) ? funct  : fn_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU controls stay stable across EXECUTE, MEMORY and WRITEBACK so the datapath may re-sample
  always_comb begin
    alu_phase  = (state_q == S_EXECUTE) || (state_q == S_MEMORY) || (state_q == S_WRITEBACK);
    ir_we      = (state_q == S_FETCH);
    pc_we      = (state_q == S_FETCH);
    rf_we      = (state_q == S_WRITEBACK);
    reg_dst    = (state_q == S_WRITEBACK) && (op_q == OP_RTYPE);
    mem_to_reg = (state_q == S_WRITEBACK) && (op_q == OP_LW);
    mem_we     = (state_q == S_MEMORY) && (op_q == OP_SW);
    busy       = (state_q == S_FETCH) || (state_q == S_DECODE) || alu_phase;
    illegal    = (state_q == S_TRAP);
    alu_src_b  = 1'b0;
    alu_op     = 3'b000;
    if (alu_phase) begin
      if (op_q == OP_RTYPE) begin
        case (fn_q)
          6'h22:   alu_op = 3'b001;
          6'h24:   alu_op = 3'b010;
          6'h25:   alu_op = 3'b011;
          default: alu_op = 3'b000;
        endcase
      end else begin
        alu_src_b = 1'b1;
      end
    end
  end

  assign count_state = state_q;
  assign instr_cnt   = cnt_q;

endmodule
